// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive front end.
// Defaults target a 50 MHz clock at 115200 baud with 16x oversampling.
package uart_pkg;

    typedef enum logic {
        StIdle,
        StRun
    } tick_state_e;

    localparam int unsigned DefBTick   = 16;
    localparam int unsigned DefDivInt  = 27;
    localparam int unsigned DefDivFrac = 2;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: programmable integer + fractional divisor,
// restarts phase from zero on every enable.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned DEF_DIV_INT  = DefDivInt,
    parameter int unsigned DEF_DIV_FRAC = DefDivFrac
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_en,
    input  logic [15:0]       div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              baud_clk
);

    tick_state_e       state_q, state_d;
    logic [15:0]       div_int_q, div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic [15:0]       per_int_q, per_int_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic              baud_clk_q, baud_clk_d;
    logic [FRAC_W:0]   acc_sum;
    logic              period_end;

    always_comb begin
        div_int_d  = div_int_q;
        div_frac_d = div_frac_q;
        if (div_load) begin
            div_int_d  = (div_int < 16'd2) ? 16'd2 : div_int;
            div_frac_d = div_frac;
        end
    end

    // per_int_q freezes the divisor for the period in progress
    assign acc_sum    = {1'b0, acc_q} + {1'b0, div_frac_q};
    assign period_end = ({1'b0, cnt_q} + 17'd1) == ({1'b0, per_int_q} + {16'd0, carry_q});

    always_comb begin
        state_d    = state_q;
        per_int_d  = per_int_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        baud_clk_d = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d   = '0;
                acc_d   = '0;
                carry_d = 1'b0;
                if (baud_en) begin
                    state_d   = StRun;
                    per_int_d = div_int_d;
                end
            end
            StRun: begin
                if (!baud_en) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    acc_d   = '0;
                    carry_d = 1'b0;
                end else if (period_end) begin
                    baud_clk_d       = 1'b1;
                    cnt_d            = '0;
                    {carry_d, acc_d} = acc_sum;
                    per_int_d        = div_int_d;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            div_int_q  <= 16'(DEF_DIV_INT);
            div_frac_q <= FRAC_W'(DEF_DIV_FRAC);
            per_int_q  <= 16'(DEF_DIV_INT);
            cnt_q      <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            baud_clk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            per_int_q  <= per_int_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            baud_clk_q <= baud_clk_d;
        end
    end

    assign baud_clk = baud_clk_q;

endmodule

// File: rtl/uart_rx_front.sv
// UART receive front end: synchronizer, majority glitch filter, falling-edge
// pulse, break detector and the oversampling tick generator.
module uart_rx_front
    import uart_pkg::*;
#(
    parameter int unsigned B_TICK       = DefBTick,
    parameter int unsigned D_W          = 8,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEF_DIV_INT  = DefDivInt,
    parameter int unsigned DEF_DIV_FRAC = DefDivFrac
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_pin,
    input  logic              baud_en,
    input  logic [15:0]       div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              rx_data,
    output logic              baud_clk,
    output logic              rx_fall,
    output logic              break_det
);

    localparam int unsigned BrkTicks = (D_W + 2) * B_TICK;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             hist_q, hist_d;
    logic [2:0]             window;
    logic                   rx_data_q, rx_data_d;
    logic                   rx_prev_q;
    logic                   rx_fall_q, rx_fall_d;
    logic [7:0]             brk_q, brk_d;
    logic                   break_det_q, break_det_d;

    // The 3-sample filter window is the two stored samples plus the one being captured,
    // so the filter adds two edges of latency on top of the synchronizer.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], rx_pin};
        window    = {hist_q, sync_q[SYNC_STAGES-1]};
        hist_d    = window[1:0];
        rx_data_d = maj3(window);
        rx_fall_d = rx_prev_q & ~rx_data_q;
    end

    always_comb begin
        brk_d       = brk_q;
        break_det_d = break_det_q;
        if (rx_data_q) begin
            brk_d       = '0;
            break_det_d = 1'b0;
        end else if (baud_clk) begin
            if (brk_q != 8'hff) begin
                brk_d = brk_q + 8'd1;
            end
            if (32'(brk_d) >= BrkTicks) begin
                break_det_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '1;
            hist_q      <= '1;
            rx_data_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_fall_q   <= 1'b0;
            brk_q       <= '0;
            break_det_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            rx_data_q   <= rx_data_d;
            rx_prev_q   <= rx_data_q;
            rx_fall_q   <= rx_fall_d;
            brk_q       <= brk_d;
            break_det_q <= break_det_d;
        end
    end

    uart_baud_tick #(
        .FRAC_W      (FRAC_W),
        .DEF_DIV_INT (DEF_DIV_INT),
        .DEF_DIV_FRAC(DEF_DIV_FRAC)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .baud_en (baud_en),
        .div_int (div_int),
        .div_frac(div_frac),
        .div_load(div_load),
        .baud_clk(baud_clk)
    );

    assign rx_data   = rx_data_q;
    assign rx_fall   = rx_fall_q;
    assign break_det = break_det_q;

endmodule

// File: tb/tb_uart_rx_front.sv
// Bench for uart_rx_front: filter vector table, tick-time scoreboard and
// hand-written sequences for enable, divisor load, break and async reset.
module tb_uart_rx_front;

    logic        clk;
    logic        rst;
    logic        rx_pin;
    logic        baud_en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        rx_data;
    logic        baud_clk;
    logic        rx_fall;
    logic        break_det;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int tick_seen = 0;
    int exp_tick[$];
    int act_tick[$];

    typedef struct {
        logic pin;
        logic data;
        logic fall;
    } vec_t;

    vec_t vecs[22];

    uart_rx_front dut (
        .clk      (clk),
        .rst      (rst),
        .rx_pin   (rx_pin),
        .baud_en  (baud_en),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .rx_data  (rx_data),
        .baud_clk (baud_clk),
        .rx_fall  (rx_fall),
        .break_det(break_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step(1);
    endtask

    task automatic wait_ticks(input int max_cyc);
        for (int i = 0; i < max_cyc && exp_tick.size() != 0; i++) step(1);
        chk("ticks_outstanding", exp_tick.size(), 0);
        exp_tick.delete();
    endtask

    task automatic load_div(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
    endtask

    // Tick monitor: every observed baud_clk pulse is matched against the scoreboard.
    initial begin
        logic prev_bc;
        prev_bc = 1'b0;
        forever begin
            @(negedge clk);
            if (baud_clk === 1'b1) begin
                tick_seen++;
                act_tick.push_back(cyc);
                chk("tick_not_back_to_back", int'(prev_bc), 0);
                if (exp_tick.size() == 0) chk("unexpected_tick", cyc, -1);
                else chk("tick_time", cyc, exp_tick.pop_front());
            end
            prev_bc = baud_clk;
        end
    end

    initial begin
        int e, t, acc, sum, ts;

        vecs = '{
            '{1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0}
        };

        rst      = 1'b0;
        rx_pin   = 1'b1;
        baud_en  = 1'b0;
        div_int  = 16'd27;
        div_frac = 4'd2;
        div_load = 1'b0;

        // Reset values, held and after release
        step(3);
        chk("rst_rx_data", int'(rx_data), 1);
        chk("rst_baud_clk", int'(baud_clk), 0);
        chk("rst_rx_fall", int'(rx_fall), 0);
        chk("rst_break_det", int'(break_det), 0);
        rst = 1'b1;
        step(3);
        chk("post_rst_rx_data", int'(rx_data), 1);
        chk("post_rst_baud_clk", int'(baud_clk), 0);
        chk("post_rst_rx_fall", int'(rx_fall), 0);
        chk("post_rst_break_det", int'(break_det), 0);

        // Filter latency and glitch rejection
        for (int i = 0; i < 22; i++) begin
            rx_pin = vecs[i].pin;
            step(1);
            chk($sformatf("filt_rx_data[%0d]", i), int'(rx_data), int'(vecs[i].data));
            chk($sformatf("filt_rx_fall[%0d]", i), int'(rx_fall), int'(vecs[i].fall));
        end
        rx_pin = 1'b1;
        step(5);

        // Fractional tick pattern: 27 + 2/16
        load_div(27, 2);
        exp_tick.delete();
        act_tick.delete();
        baud_en = 1'b1;
        e   = cyc + 1;
        t   = e + 27;
        acc = 0;
        for (int k = 0; k < 17; k++) begin
            exp_tick.push_back(t);
            sum = acc + 2;
            t   = t + 27 + ((sum >= 16) ? 1 : 0);
            acc = sum % 16;
        end
        wait_ticks(1000);
        baud_en = 1'b0;
        if (act_tick.size() >= 17) chk("span_16_ticks", act_tick[16] - act_tick[0], 434);
        else chk("span_16_ticks_count", act_tick.size(), 17);
        step(3);

        // Enable dropped one cycle before the tick is due
        baud_en = 1'b1;
        e = cyc + 1;
        wait_cyc(e + 26);
        baud_en = 1'b0;
        ts = tick_seen;
        step(40);
        chk("no_tick_after_drop", tick_seen - ts, 0);

        // Re-enable, then load div_int = 1 mid-period
        baud_en = 1'b1;
        e = cyc + 1;
        t = e + 27;
        exp_tick.push_back(t);
        exp_tick.push_back(t + 27);
        for (int k = 1; k <= 3; k++) exp_tick.push_back(t + 27 + 2 * k);
        wait_cyc(t + 10);
        load_div(1, 0);
        wait_ticks(200);
        baud_en = 1'b0;
        step(10);
        chk("no_tick_after_load_drop", exp_tick.size(), 0);

        // Break detection: 160 ticks of low line at divisor 4
        load_div(4, 0);
        step(2);
        rx_pin  = 1'b0;
        baud_en = 1'b1;
        e = cyc + 1;
        for (int k = 1; k <= 164; k++) exp_tick.push_back(e + 4 * k);
        wait_cyc(e + 639);
        chk("brk_before_159", int'(break_det), 0);
        wait_cyc(e + 640);
        chk("brk_at_160th_tick", int'(break_det), 0);
        wait_cyc(e + 641);
        chk("brk_set", int'(break_det), 1);
        wait_cyc(e + 650);
        rx_pin = 1'b1;
        wait_cyc(e + 654);
        chk("brk_hold_4", int'(break_det), 1);
        chk("brk_rx_data_back", int'(rx_data), 1);
        wait_cyc(e + 655);
        chk("brk_clear_5", int'(break_det), 0);
        wait_cyc(e + 658);
        baud_en = 1'b0;
        step(10);
        chk("brk_ticks_left", exp_tick.size(), 0);
        exp_tick.delete();

        // Async reset while a tick is high
        baud_en = 1'b1;
        e = cyc + 1;
        exp_tick.push_back(e + 4);
        wait_cyc(e + 4);
        @(negedge clk);
        #1;
        chk("tick_before_rst", int'(baud_clk), 1);
        rst = 1'b0;
        #1;
        chk("async_rst_baud_clk", int'(baud_clk), 0);
        chk("async_rst_rx_data", int'(rx_data), 1);
        chk("async_rst_break_det", int'(break_det), 0);
        baud_en = 1'b0;
        step(2);
        rst = 1'b1;
        step(3);
        chk("rst_ticks_left", exp_tick.size(), 0);
        exp_tick.delete();

        // Reset restores the default divisor 27 + 2/16
        baud_en = 1'b1;
        e = cyc + 1;
        exp_tick.push_back(e + 27);
        exp_tick.push_back(e + 54);
        wait_ticks(200);
        baud_en = 1'b0;
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
